// File: rtl/sram_ctrl_2mb_if.sv
// sram_ctrl_2mb_if: requester-side bus of the SRAM controller (CPU read/write port, video read port).
// Latency: none, signal bundle only.
// Backpressure: level requests held stable by the master until the matching one-cycle ack.
interface sram_ctrl_2mb_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [20:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        vid_req;
    logic [20:0] vid_addr;
    logic [7:0]  vid_rdata;
    logic        vid_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr,
        input  cpu_rdata, cpu_ack, vid_rdata, vid_ack
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr,
        output cpu_rdata, cpu_ack, vid_rdata, vid_ack
    );
endinterface

// File: rtl/sram_ctrl_2mb.sv
// sram_ctrl_2mb: arbitrating controller for a 2 MB async 8-bit SRAM; CPU r/w port plus optional video read port (macro SRAM_VIDEO_PORT_EN).
// Latency: request sampled in IDLE at edge k, ack high in cycle k+ACCESS_CYCLES+1; one access per ACCESS_CYCLES+2 cycles.
// Backpressure: level requests held until ack; under contention grants alternate video/CPU; a granted access always completes.
module sram_ctrl_2mb #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic           clk_100,
    input  logic           reset,
    sram_ctrl_2mb_if.slave bus,
    output logic [20:0]    SRAM_ADDR,
    inout  wire  [7:0]     SRAM_DATA,
    output logic           SRAM_WE_n
);
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic        r_drive;
    logic [7:0]  r_wdata;
    logic [20:0] r_addr;
    logic        r_we_n;
    logic [7:0]  r_cpu_rdata;
    logic        r_cpu_ack;

    logic        w_grant;
    logic        w_grant_vid;
    logic        w_we;
    logic [20:0] w_addr;

`ifdef SRAM_VIDEO_PORT_EN
    logic        r_last_vid;
    logic        r_port_vid;
    logic        r_vid_ack;
    logic [7:0]  r_vid_rdata;

    // Video wins contention unless it held the previous grant, so contended grants alternate.
    always_comb begin
        w_grant_vid = bus.vid_req && (!bus.cpu_req || !r_last_vid);
        w_grant     = bus.cpu_req || bus.vid_req;
    end

    assign bus.vid_ack   = r_vid_ack;
    assign bus.vid_rdata = r_vid_rdata;
`else
    logic w_unused_vid;

    assign w_grant_vid   = 1'b0;
    assign w_grant       = bus.cpu_req;
    assign w_unused_vid  = ^{bus.vid_req, bus.vid_addr};
    assign bus.vid_ack   = 1'b0;
    assign bus.vid_rdata = 8'h00;
`endif

    // Video never writes; select the granted port's command.
    always_comb begin
        w_we   = w_grant_vid ? 1'b0 : bus.cpu_we;
        w_addr = w_grant_vid ? bus.vid_addr : bus.cpu_addr;
    end

    // Access sequencer: pins are registered; write data stays on the bus through TURN for hold time.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_drive     <= 1'b0;
            r_wdata     <= 8'h00;
            r_addr      <= 21'd0;
            r_we_n      <= 1'b1;
            r_cpu_rdata <= 8'h00;
            r_cpu_ack   <= 1'b0;
`ifdef SRAM_VIDEO_PORT_EN
            r_last_vid  <= 1'b0;
            r_port_vid  <= 1'b0;
            r_vid_ack   <= 1'b0;
            r_vid_rdata <= 8'h00;
`endif
        end else begin
            r_cpu_ack <= 1'b0;
`ifdef SRAM_VIDEO_PORT_EN
            r_vid_ack <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state <= ACCESS;
                        r_we    <= w_we;
                        r_addr  <= w_addr;
                        r_wdata <= bus.cpu_wdata;
                        r_cnt   <= CNT_LOAD;
                        r_we_n  <= !w_we;
                        r_drive <= w_we;
`ifdef SRAM_VIDEO_PORT_EN
                        r_port_vid <= w_grant_vid;
                        r_last_vid <= w_grant_vid;
`endif
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= TURN;
                        r_we_n  <= 1'b1;
`ifdef SRAM_VIDEO_PORT_EN
                        if (r_port_vid) begin
                            r_vid_ack <= 1'b1;
                            if (!r_we) r_vid_rdata <= SRAM_DATA;
                        end else begin
                            r_cpu_ack <= 1'b1;
                            if (!r_we) r_cpu_rdata <= SRAM_DATA;
                        end
`else
                        r_cpu_ack <= 1'b1;
                        if (!r_we) r_cpu_rdata <= SRAM_DATA;
`endif
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                TURN: begin
                    r_drive <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_drive <= 1'b0;
                    r_we_n  <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign SRAM_ADDR     = r_addr;
    assign SRAM_WE_n     = r_we_n;
    assign SRAM_DATA     = r_drive ? r_wdata : 8'bz;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.cpu_rdata = r_cpu_rdata;
endmodule
